hififo_request_sched: RTL and testbench

Per-channel request queue and scheduler for the HIFIFO DMA engines, parametrised in channel count and queue depth. Host software writes page-table entries (bus address, length, interrupt flag) over PIO into per-channel circular queues held in one shared block RAM. A work-conserving round-robin arbiter hands entries to the FIFO engines as soon as they are ready, instead of using fixed time slots. Per-channel flush, fill level and sticky overflow are added for driver recovery.

---
 rtl/hififo_request_sched.sv | 182 ++++++++++++++++++
 tb/tb_hififo_request_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hififo_request_sched.sv
// Per-channel circular request queues in one shared RAM, drained by a
// work-conserving round-robin arbiter with a fixed 2-cycle delivery latency.
module hififo_request_sched #(
  parameter int         NCH        = 8,
  parameter logic [7:0] ENABLES    = 8'b00010001,
  parameter int         DEPTH_LOG2 = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pio_wvalid,
  input  logic [63:0]                   pio_wdata,
  input  logic [10:0]                   pio_addr,
  output logic [NCH-1:0]                r_valid,
  output logic [60:0]                   r_addr,
  output logic [18:0]                   r_count,
  output logic                          r_interrupt,
  input  logic [NCH-1:0]                r_ready,
  output logic [NCH*(DEPTH_LOG2+1)-1:0] q_level,
  output logic [NCH-1:0]                q_overflow
);

  localparam int PW     = DEPTH_LOG2 + 1;
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW     = CW + DEPTH_LOG2;
  localparam int NWORDS = NCH << DEPTH_LOG2;

  typedef struct packed {
    logic        interrupt;
    logic [18:0] count;
  } high_t;

  typedef struct packed {
    high_t       hi;
    logic [60:0] addr;
  } entry_t;

  function automatic logic chan_ok(input logic [2:0] ch);
    return (int'(ch) < NCH) && ENABLES[ch];
  endfunction

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
    int v;
    v = int'(base) + off;
    if (v >= NCH) v = v - NCH;
    return CW'(v);
  endfunction

  logic       stage_wr, push_wr, flush_wr;
  logic [2:0] push_ch, flush_ch;
  logic       unused_wdata;

  assign stage_wr     = pio_wvalid && (pio_addr[10:4] == 7'd1) && !pio_addr[0];
  assign push_wr      = pio_wvalid && (pio_addr[10:4] == 7'd1) && pio_addr[0] && chan_ok(pio_addr[3:1]);
  assign flush_wr     = pio_wvalid && (pio_addr[10:4] == 7'd2) && pio_wdata[0] && chan_ok(pio_addr[2:0]);
  assign push_ch      = pio_addr[3:1];
  assign flush_ch     = pio_addr[2:0];
  assign unused_wdata = ^pio_wdata[2:1];

  entry_t          mem [NWORDS];
  entry_t          mem_wdata;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;

  high_t           staged_q, staged_d;
  logic [PW-1:0]   p_in_q [NCH];
  logic [PW-1:0]   p_in_d [NCH];
  logic [PW-1:0]   p_out_q [NCH];
  logic [PW-1:0]   p_out_d [NCH];
  logic [PW-1:0]   level [NCH];
  logic [NCH-1:0]  ovf_q, ovf_d, elig;
  logic [CW-1:0]   rr_q, rr_d, s1_ch_q, s1_ch_d, gnt_ch;
  logic            s1_valid_q, s1_valid_d, gnt;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [NCH-1:0]  r_valid_q, r_valid_d;
  entry_t          r_entry_q, r_entry_d;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    staged_d = staged_q;
    if (stage_wr) staged_d = '{interrupt: pio_wdata[32], count: pio_wdata[21:3]};
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '{hi: staged_q, addr: pio_wdata[63:3]};
    ovf_d     = ovf_q;
    q_level   = '0;

    for (int c = 0; c < NCH; c++) begin
      p_in_d[c]  = p_in_q[c];
      p_out_d[c] = p_out_q[c];
      level[c]   = p_in_q[c] - p_out_q[c];
      q_level[c*PW +: PW] = level[c];
      // A channel with its entry still in the read stage, or being flushed, sits out.
      elig[c] = ENABLES[c] && r_ready[c] && (level[c] != '0)
                && !(s1_valid_q && (int'(s1_ch_q) == c))
                && !(flush_wr && (int'(flush_ch) == c));
      if (push_wr && (int'(push_ch) == c)) begin
        if (level[c][DEPTH_LOG2]) begin
          ovf_d[c] = 1'b1;
        end else begin
          p_in_d[c] = p_in_q[c] + 1'b1;
          mem_we    = 1'b1;
          mem_waddr = {CW'(c), p_in_q[c][DEPTH_LOG2-1:0]};
        end
      end
      if (flush_wr && (int'(flush_ch) == c)) begin
        p_out_d[c] = p_in_q[c];
        ovf_d[c]   = 1'b0;
      end
    end

    gnt    = 1'b0;
    gnt_ch = rr_q;
    for (int i = 0; i < NCH; i++) begin
      if (!gnt && elig[rr_idx(rr_q, i)]) begin
        gnt    = 1'b1;
        gnt_ch = rr_idx(rr_q, i);
      end
    end

    rr_d       = rr_q;
    s1_valid_d = gnt;
    s1_ch_d    = s1_ch_q;
    rd_addr_d  = rd_addr_q;
    if (gnt) begin
      p_out_d[gnt_ch] = p_out_q[gnt_ch] + 1'b1;
      rd_addr_d       = {gnt_ch, p_out_q[gnt_ch][DEPTH_LOG2-1:0]};
      s1_ch_d         = gnt_ch;
      rr_d            = rr_idx(gnt_ch, 1);
    end

    // Read sees the pre-edge word, so a push into a just-freed slot cannot corrupt it.
    r_valid_d = '0;
    r_entry_d = r_entry_q;
    if (s1_valid_q) begin
      r_valid_d[s1_ch_q] = 1'b1;
      r_entry_d          = mem[rd_addr_q];
    end
  end

  // NOTE: queue storage has no reset; the pointers alone define which words are live.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      staged_q   <= '0;
      ovf_q      <= '0;
      rr_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      rd_addr_q  <= '0;
      r_valid_q  <= '0;
      r_entry_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        p_in_q[c]  <= '0;
        p_out_q[c] <= '0;
      end
    end else begin
      staged_q   <= staged_d;
      ovf_q      <= ovf_d;
      rr_q       <= rr_d;
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      rd_addr_q  <= rd_addr_d;
      r_valid_q  <= r_valid_d;
      r_entry_q  <= r_entry_d;
      for (int c = 0; c < NCH; c++) begin
        p_in_q[c]  <= p_in_d[c];
        p_out_q[c] <= p_out_d[c];
      end
    end
  end

  assign r_valid     = r_valid_q;
  assign r_addr      = r_entry_q.addr;
  assign r_count     = r_entry_q.hi.count;
  assign r_interrupt = r_entry_q.hi.interrupt;
  assign q_overflow  = ovf_q;

endmodule

// File: tb/tb_hififo_request_sched.sv
// Directed bench: instance a uses the default build, instance b has all
// channels enabled with 4-entry queues for fill, arbitration and flush cases.
module tb_hififo_request_sched;

  logic        clock = 1'b0;
  logic        reset;

  logic        a_wvalid, b_wvalid;
  logic [63:0] a_wdata, b_wdata;
  logic [10:0] a_addr, b_addr;
  logic [7:0]  a_ready, b_ready;
  logic [7:0]  a_valid, b_valid;
  logic [60:0] a_raddr, b_raddr;
  logic [18:0] a_rcount, b_rcount;
  logic        a_rint, b_rint;
  logic [55:0] a_level;
  logic [23:0] b_level;
  logic [7:0]  a_ovf, b_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  hififo_request_sched #(.NCH(8), .ENABLES(8'b00010001), .DEPTH_LOG2(6)) dut_a (
    .clock(clock), .reset(reset),
    .pio_wvalid(a_wvalid), .pio_wdata(a_wdata), .pio_addr(a_addr),
    .r_valid(a_valid), .r_addr(a_raddr), .r_count(a_rcount), .r_interrupt(a_rint),
    .r_ready(a_ready), .q_level(a_level), .q_overflow(a_ovf)
  );

  hififo_request_sched #(.NCH(8), .ENABLES(8'hFF), .DEPTH_LOG2(2)) dut_b (
    .clock(clock), .reset(reset),
    .pio_wvalid(b_wvalid), .pio_wdata(b_wdata), .pio_addr(b_addr),
    .r_valid(b_valid), .r_addr(b_raddr), .r_count(b_rcount), .r_interrupt(b_rint),
    .r_ready(b_ready), .q_level(b_level), .q_overflow(b_ovf)
  );

  task automatic pio_write(input bit sel_b, input logic [10:0] addr, input logic [63:0] data);
    @(negedge clock);
    if (sel_b) begin
      b_wvalid = 1'b1; b_addr = addr; b_wdata = data;
    end else begin
      a_wvalid = 1'b1; a_addr = addr; a_wdata = data;
    end
    @(negedge clock);
    a_wvalid = 1'b0;
    b_wvalid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (a_valid !== 8'h00)   begin errors++; $display("FAIL reset_a_valid got %h want 00", a_valid); end
    checks++; if (a_raddr !== 61'h0)   begin errors++; $display("FAIL reset_a_addr got %h want 0", a_raddr); end
    checks++; if (a_rcount !== 19'h0)  begin errors++; $display("FAIL reset_a_count got %h want 0", a_rcount); end
    checks++; if (a_rint !== 1'b0)     begin errors++; $display("FAIL reset_a_int got %b want 0", a_rint); end
    checks++; if (a_level !== 56'h0)   begin errors++; $display("FAIL reset_a_level got %h want 0", a_level); end
    checks++; if (a_ovf !== 8'h00)     begin errors++; $display("FAIL reset_a_ovf got %h want 00", a_ovf); end
    checks++; if (b_valid !== 8'h00)   begin errors++; $display("FAIL reset_b_valid got %h want 00", b_valid); end
    checks++; if (b_level !== 24'h0)   begin errors++; $display("FAIL reset_b_level got %h want 0", b_level); end
  endtask

  task automatic test_single_push;
    int n;
    int pk;
    logic [60:0] ga;
    logic [18:0] gc;
    logic gi;
    n = 0; pk = 0; ga = '0; gc = '0; gi = 1'b0;
    pio_write(1'b0, 11'h010, 64'h0000_0001_0000_0028);
    pio_write(1'b0, 11'h011, 64'h0000_0000_0000_1000);
    checks++; if (a_level[6:0] !== 7'd1) begin errors++; $display("FAIL push_level got %0d want 1", a_level[6:0]); end
    a_ready = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) begin
        checks++; if (a_level[6:0] !== 7'd0) begin errors++; $display("FAIL grant_level got %0d want 0", a_level[6:0]); end
      end
      if (a_valid !== 8'h00) begin
        checks++; if (a_valid !== 8'h01) begin errors++; $display("FAIL push_onehot got %h want 01", a_valid); end
        n++; pk = k; ga = a_raddr; gc = a_rcount; gi = a_rint;
      end
    end
    checks++; if (n !== 1)           begin errors++; $display("FAIL push_pulses got %0d want 1", n); end
    checks++; if (pk !== 2)          begin errors++; $display("FAIL push_latency got %0d want 2", pk); end
    checks++; if (ga !== 61'h200)    begin errors++; $display("FAIL push_addr got %h want 200", ga); end
    checks++; if (gc !== 19'd5)      begin errors++; $display("FAIL push_count got %0d want 5", gc); end
    checks++; if (gi !== 1'b1)       begin errors++; $display("FAIL push_int got %b want 1", gi); end
    checks++; if (a_raddr !== 61'h200) begin errors++; $display("FAIL push_addr_hold got %h want 200", a_raddr); end
    a_ready = 8'h00;
  endtask

  task automatic test_disabled;
    pio_write(1'b0, 11'h010, 64'h38);
    pio_write(1'b0, 11'h013, 64'h800);
    a_ready = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      checks++; if (a_valid !== 8'h00) begin errors++; $display("FAIL disabled_valid k=%0d got %h want 00", k, a_valid); end
    end
    checks++; if (a_level !== 56'h0) begin errors++; $display("FAIL disabled_level got %h want 0", a_level); end
    checks++; if (a_ovf !== 8'h00)   begin errors++; $display("FAIL disabled_ovf got %h want 00", a_ovf); end
    a_ready = 8'h00;
  endtask

  task automatic test_fill;
    int n;
    int pk [4];
    logic [60:0] pa [4];
    n = 0;
    b_ready = 8'h00;
    pio_write(1'b1, 11'h010, 64'h38);
    for (int i = 0; i < 5; i++) pio_write(1'b1, 11'h019, 64'(64'h40 + i) << 3);
    checks++; if (b_level[14:12] !== 3'd4) begin errors++; $display("FAIL fill_level got %0d want 4", b_level[14:12]); end
    checks++; if (b_ovf !== 8'h10)         begin errors++; $display("FAIL fill_ovf got %h want 10", b_ovf); end
    b_ready = 8'h10;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (b_valid !== 8'h00) begin
        checks++; if (b_valid !== 8'h10) begin errors++; $display("FAIL fill_onehot got %h want 10", b_valid); end
        if (n < 4) begin pk[n] = k; pa[n] = b_raddr; end
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL fill_pulses got %0d want 4", n); end
    for (int j = 0; j < 4 && j < n; j++) begin
      checks++; if (pk[j] !== 2 + 2*j) begin errors++; $display("FAIL fill_cycle%0d got %0d want %0d", j, pk[j], 2 + 2*j); end
      checks++; if (pa[j] !== 61'(64'h40 + j)) begin errors++; $display("FAIL fill_addr%0d got %h want %h", j, pa[j], 64'h40 + j); end
    end
    checks++; if (b_rcount !== 19'd7) begin errors++; $display("FAIL fill_count got %0d want 7", b_rcount); end
    b_ready = 8'h00;
  endtask

  task automatic test_round_robin;
    int rr_ch [3];
    int ech;
    logic [7:0] ev;
    rr_ch = '{0, 4, 6};
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    b_ready = 8'h00;
    pio_write(1'b1, 11'h010, 64'h0000_0001_0000_0018);
    for (int n = 0; n < 3; n++)
      for (int j = 0; j < 3; j++)
        pio_write(1'b1, 11'(11'h011 | (rr_ch[j] << 1)), 64'(rr_ch[j]*16 + n) << 3);
    b_ready = 8'hFF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k >= 2 && k <= 10) begin
        ech = rr_ch[(k-2) % 3];
        ev  = 8'b1 << ech;
        checks++; if (b_valid !== ev) begin errors++; $display("FAIL rr_valid k=%0d got %h want %h", k, b_valid, ev); end
        checks++; if (b_raddr !== 61'(ech*16 + (k-2)/3)) begin errors++; $display("FAIL rr_addr k=%0d got %h want %h", k, b_raddr, ech*16 + (k-2)/3); end
      end else begin
        checks++; if (b_valid !== 8'h00) begin errors++; $display("FAIL rr_idle k=%0d got %h want 00", k, b_valid); end
      end
    end
    checks++; if (b_level !== 24'h0) begin errors++; $display("FAIL rr_level got %h want 0", b_level); end
    b_ready = 8'h00;
  endtask

  task automatic test_flush_in_flight;
    b_ready = 8'h00;
    for (int i = 0; i < 5; i++) pio_write(1'b1, 11'h011, 64'(64'h70 + i) << 3);
    checks++; if (b_level[2:0] !== 3'd4) begin errors++; $display("FAIL flush_pre_level got %0d want 4", b_level[2:0]); end
    checks++; if (b_ovf !== 8'h01)       begin errors++; $display("FAIL flush_pre_ovf got %h want 01", b_ovf); end
    b_ready = 8'h01;
    @(negedge clock);
    checks++; if (b_level[2:0] !== 3'd3) begin errors++; $display("FAIL flush_grant_level got %0d want 3", b_level[2:0]); end
    b_wvalid = 1'b1; b_addr = 11'h020; b_wdata = 64'h1;
    @(negedge clock);
    b_wvalid = 1'b0;
    checks++; if (b_valid !== 8'h01)  begin errors++; $display("FAIL flush_valid got %h want 01", b_valid); end
    checks++; if (b_raddr !== 61'h70) begin errors++; $display("FAIL flush_addr got %h want 70", b_raddr); end
    checks++; if (b_level !== 24'h0)  begin errors++; $display("FAIL flush_level got %h want 0", b_level); end
    checks++; if (b_ovf !== 8'h00)    begin errors++; $display("FAIL flush_ovf got %h want 00", b_ovf); end
    for (int k = 3; k <= 8; k++) begin
      @(negedge clock);
      checks++; if (b_valid !== 8'h00) begin errors++; $display("FAIL flush_after k=%0d got %h want 00", k, b_valid); end
    end
    b_ready = 8'h00;
  endtask

  task automatic test_reset_in_flight;
    b_ready = 8'h00;
    pio_write(1'b1, 11'h011, 64'h55 << 3);
    b_ready = 8'h01;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (b_valid !== 8'h00)  begin errors++; $display("FAIL rst_valid got %h want 00", b_valid); end
    checks++; if (b_raddr !== 61'h0)  begin errors++; $display("FAIL rst_addr got %h want 0", b_raddr); end
    checks++; if (b_rcount !== 19'h0) begin errors++; $display("FAIL rst_count got %h want 0", b_rcount); end
    checks++; if (b_rint !== 1'b0)    begin errors++; $display("FAIL rst_int got %b want 0", b_rint); end
    checks++; if (b_level !== 24'h0)  begin errors++; $display("FAIL rst_level got %h want 0", b_level); end
    checks++; if (b_ovf !== 8'h00)    begin errors++; $display("FAIL rst_ovf got %h want 00", b_ovf); end
    b_ready = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++; if (b_valid !== 8'h00) begin errors++; $display("FAIL rst_after k=%0d got %h want 00", k, b_valid); end
    end
    pio_write(1'b1, 11'h019, 64'h66 << 3);
    pio_write(1'b1, 11'h011, 64'h65 << 3);
    b_ready = 8'h11;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 2) begin
        checks++; if (b_valid !== 8'h01)  begin errors++; $display("FAIL rst_rr_first got %h want 01", b_valid); end
        checks++; if (b_raddr !== 61'h65) begin errors++; $display("FAIL rst_rr_addr0 got %h want 65", b_raddr); end
        checks++; if (b_rcount !== 19'h0) begin errors++; $display("FAIL rst_staged got %h want 0", b_rcount); end
      end
      if (k == 3) begin
        checks++; if (b_valid !== 8'h10)  begin errors++; $display("FAIL rst_rr_second got %h want 10", b_valid); end
        checks++; if (b_raddr !== 61'h66) begin errors++; $display("FAIL rst_rr_addr4 got %h want 66", b_raddr); end
      end
    end
    b_ready = 8'h00;
  endtask

  initial begin
    reset    = 1'b1;
    a_wvalid = 1'b0; a_wdata = '0; a_addr = '0; a_ready = '0;
    b_wvalid = 1'b0; b_wdata = '0; b_addr = '0; b_ready = '0;
    test_reset;
    test_single_push;
    test_disabled;
    test_fill;
    test_round_robin;
    test_flush_in_flight;
    test_reset_in_flight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
